rat_checkpoint: RTL

Register alias table (arch→phys tag map) with branch checkpoint storage, directly downstream of the branch buffer. On Copy_RAT it snapshots the live map into slot tail_num. On Paste_RAT it restores the live map from slot head_num, recovering rename state after a mispredicted jump/branch. Rename stage reads source tags here and writes new destination mappings.

---
 rtl/rat_checkpoint.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rat_checkpoint.sv
// Register alias table with branch checkpoints.
// Ports: rs1/rs2 tag reads, rename write with old-tag
// read, Copy_RAT/tail_num snapshot, Paste_RAT/head_num
// restore, ckpt_valid slot bits, restore_done and
// restore_err pulses. Optional macro
// RAT_CKPT_OVERFLOW_CHECK_EN adds sticky ckpt_overflow.
module rat_checkpoint #(
   parameter int ARCH_REGS  = 32,
   parameter int TAG_W      = 6,
   parameter int CKPT_DEPTH = 8,
   parameter int CKPT_W     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            rs1_addr,
   input  logic [4:0]            rs2_addr,
   output logic [TAG_W-1:0]      rs1_tag,
   output logic [TAG_W-1:0]      rs2_tag,
   input  logic                  rename_valid,
   input  logic [4:0]            rename_rd,
   input  logic [TAG_W-1:0]      rename_tag,
   output logic [TAG_W-1:0]      rd_old_tag,
   input  logic                  Copy_RAT,
   input  logic [CKPT_W-1:0]     tail_num,
   input  logic                  Paste_RAT,
   input  logic [CKPT_W-1:0]     head_num,
   output logic [CKPT_DEPTH-1:0] ckpt_valid,
   output logic                  restore_done,
`ifdef RAT_CKPT_OVERFLOW_CHECK_EN
   output logic                  ckpt_overflow,
`endif
   output logic                  restore_err
);

   typedef logic [TAG_W-1:0] tag_t;
   typedef tag_t map_t [ARCH_REGS];

   map_t live_q;
   map_t live_d;
   map_t ren_map;
   map_t ckpt_q [CKPT_DEPTH];
   map_t ckpt_d [CKPT_DEPTH];

   logic [CKPT_DEPTH-1:0] ckpt_valid_q;
   logic [CKPT_DEPTH-1:0] ckpt_valid_d;
   logic                  done_q;
   logic                  done_d;
   logic                  err_q;
   logic                  err_d;
   logic                  paste_ok;
   logic                  ren_we;

`ifdef RAT_CKPT_OVERFLOW_CHECK_EN
   logic ovf_q;
   logic ovf_d;
`endif

   // x0 is hardwired to tag 0 on every read path
   assign rs1_tag = (rs1_addr == 5'd0) ? '0
                  : live_q[rs1_addr];
   assign rs2_tag = (rs2_addr == 5'd0) ? '0
                  : live_q[rs2_addr];
   assign rd_old_tag = (rename_rd == 5'd0) ? '0
                     : live_q[rename_rd];

   assign ckpt_valid   = ckpt_valid_q;
   assign restore_done = done_q;
   assign restore_err  = err_q;

   assign paste_ok = Paste_RAT && ckpt_valid_q[head_num];
   assign ren_we   = rename_valid && (rename_rd != 5'd0);

   always_comb begin
      // map as it looks after this cycle's rename;
      // checkpoints capture this so a link reg survives
      ren_map = live_q;
      if (ren_we) begin
         ren_map[rename_rd] = rename_tag;
      end

      live_d       = ren_map;
      ckpt_d       = ckpt_q;
      ckpt_valid_d = ckpt_valid_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
`ifdef RAT_CKPT_OVERFLOW_CHECK_EN
      ovf_d        = ovf_q;
`endif

      if (paste_ok) begin
         // valid restore wins over copy and rename
         live_d       = ckpt_q[head_num];
         ckpt_valid_d = '0;
         done_d       = 1'b1;
      end else begin
         err_d = Paste_RAT;
         if (Copy_RAT) begin
`ifdef RAT_CKPT_OVERFLOW_CHECK_EN
            if (ckpt_valid_q[tail_num]) begin
               ovf_d = 1'b1;
            end
`endif
            ckpt_d[tail_num]       = ren_map;
            ckpt_valid_d[tail_num] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            live_q[i] <= tag_t'(i);
         end
         for (int s = 0; s < CKPT_DEPTH; s++) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
               ckpt_q[s][i] <= tag_t'(i);
            end
         end
         ckpt_valid_q <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef RAT_CKPT_OVERFLOW_CHECK_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         live_q       <= live_d;
         ckpt_q       <= ckpt_d;
         ckpt_valid_q <= ckpt_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
`ifdef RAT_CKPT_OVERFLOW_CHECK_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

`ifdef RAT_CKPT_OVERFLOW_CHECK_EN
   assign ckpt_overflow = ovf_q;
`endif

endmodule
